// File: rtl/ref_lock_pkg.sv
// ref_lock_pkg: state encoding and default parameters shared by the reference lock monitor.
package ref_lock_pkg;
  typedef enum logic [1:0] {
    NO_REF   = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2,
    HOLDOVER = 2'd3
  } state_t;
  localparam int DEF_CNT_W        = 16;
  localparam int DEF_REF_GATE     = 8;
  localparam int DEF_EXPECT       = 12288;
  localparam int DEF_TOL          = 4;
  localparam int DEF_LOCK_WINDOWS = 4;
  localparam int DEF_MISS_TIMEOUT = 4096;
  localparam int DEF_HOLD_MAX     = 1000000;
endpackage

// File: rtl/ref_edge_sync.sv
// ref_edge_sync: two-flop synchroniser plus registered rising-edge pulse for an asynchronous reference.
module ref_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);
  logic [2:0] sh;
  always_ff @(posedge clk) begin
    if (rst) begin
      sh <= '0;
      pulse <= 1'b0;
    end else begin
      sh <= {sh[1:0], din};
      pulse <= sh[1] & ~sh[2];
    end
  end
endmodule

// File: rtl/ref_lock_monitor.sv
// ref_lock_monitor: reference presence and frequency-lock monitor selecting the XO tune source.
// Define HOLDOVER_EN to tri-state the tune pin (HOLDOVER) when the reference is lost while locked.
module ref_lock_monitor
  import ref_lock_pkg::*;
#(
  parameter int CNT_W        = DEF_CNT_W,
  parameter int REF_GATE     = DEF_REF_GATE,
  parameter int EXPECT       = DEF_EXPECT,
  parameter int TOL          = DEF_TOL,
  parameter int LOCK_WINDOWS = DEF_LOCK_WINDOWS,
  parameter int MISS_TIMEOUT = DEF_MISS_TIMEOUT,
  parameter int HOLD_MAX     = DEF_HOLD_MAX
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Ref_In,
  input  logic                Pfd_In,
  input  logic                Center_In,
  output logic                XO_Tune,
  output logic                XO_Tune_OE,
  output logic                Ref_OK,
  output logic                Lock_OK,
  output logic signed [CNT_W:0] Freq_Err,
  output logic                Err_Valid,
  output logic [1:0]          State
);
  localparam int EW = $clog2(REF_GATE + 1);
  localparam int GW = $clog2(LOCK_WINDOWS + 1);
  localparam int MW = $clog2(MISS_TIMEOUT + 1);
  localparam int HW = $clog2(HOLD_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic signed [CNT_W:0] EXP_V = (CNT_W+1)'(EXPECT);
  localparam logic signed [CNT_W:0] TOL_V = (CNT_W+1)'(TOL);
`ifdef HOLDOVER_EN
  localparam state_t LOST = HOLDOVER;
`else
  localparam state_t LOST = NO_REF;
`endif
  state_t state, state_nx;
  logic edge_p, miss, win_end, good;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [EW-1:0] ecnt, ecnt_nx;
  logic [GW-1:0] gcnt, gcnt_nx;
  logic [MW-1:0] mcnt;
  logic [HW-1:0] hcnt;
  logic signed [CNT_W:0] err;

  ref_edge_sync u_sync (.clk(Clk), .rst(Reset), .din(Ref_In), .pulse(edge_p));

  assign miss = mcnt == MW'(MISS_TIMEOUT - 1);
  assign err  = $signed({1'b0, cnt}) - EXP_V;
  assign good = cnt != CNT_MAX && err <= TOL_V && err >= -TOL_V;
  assign State = state;

  // cnt == 0 means no window is open: the next edge only starts one
  always_comb begin
    cnt_nx = cnt;
    ecnt_nx = ecnt;
    win_end = 1'b0;
    if (miss) begin
      cnt_nx = '0;
      ecnt_nx = '0;
    end else if (edge_p && cnt == '0) begin
      cnt_nx = CNT_W'(1);
    end else if (edge_p && ecnt == EW'(REF_GATE - 1)) begin
      win_end = 1'b1;
      cnt_nx = CNT_W'(1);
      ecnt_nx = '0;
    end else if (cnt != '0) begin
      cnt_nx = cnt == CNT_MAX ? cnt : cnt + 1'b1;
      ecnt_nx = ecnt + EW'(edge_p);
    end
  end

  always_comb begin
    state_nx = state;
    gcnt_nx = miss ? '0 : gcnt;
    case (state)
      NO_REF: begin
        if (!miss && edge_p && cnt != '0) state_nx = ACQUIRE;
      end
      ACQUIRE: begin
        if (miss) state_nx = NO_REF;
        else if (win_end) begin
          gcnt_nx = good ? gcnt + 1'b1 : '0;
          if (good && gcnt == GW'(LOCK_WINDOWS - 1)) state_nx = LOCKED;
        end
      end
      LOCKED: begin
        if (miss) state_nx = LOST;
        else if (win_end && !good) begin
          state_nx = ACQUIRE;
          gcnt_nx = '0;
        end
      end
      default: begin
        if (edge_p) state_nx = ACQUIRE;
        else if (hcnt == HW'(HOLD_MAX - 1)) state_nx = NO_REF;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= NO_REF;
      cnt <= '0;
      ecnt <= '0;
      gcnt <= '0;
      mcnt <= '0;
      hcnt <= '0;
      XO_Tune <= 1'b0;
      XO_Tune_OE <= 1'b1;
      Ref_OK <= 1'b0;
      Lock_OK <= 1'b0;
      Freq_Err <= '0;
      Err_Valid <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      ecnt <= ecnt_nx;
      gcnt <= gcnt_nx;
      mcnt <= edge_p ? '0 : mcnt == MW'(MISS_TIMEOUT) ? mcnt : mcnt + 1'b1;
      hcnt <= state == HOLDOVER ? hcnt + 1'b1 : '0;
      XO_Tune <= state_nx == NO_REF ? Center_In : Pfd_In;
      XO_Tune_OE <= state_nx != HOLDOVER;
      Ref_OK <= state_nx == ACQUIRE || state_nx == LOCKED;
      Lock_OK <= state_nx == LOCKED;
      Err_Valid <= win_end;
      if (win_end) Freq_Err <= err;
    end
  end
endmodule
